// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM state encodings, grant modes
// and a width helper used by the arbiter and its picker.
package mem_arbiter_pkg;

    localparam int ARB_STATE_W = 2;

    typedef enum logic [ARB_STATE_W-1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_e;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Returns clog2(v), but never less than one bit.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/mem_arbiter_picker.sv
// Combinational grant picker: fixed priority (lowest index) or round robin
// starting one past the last winner. Reusable by other bus blocks.
module arb_picker #(
    parameter int NUM_CH = 2,
    parameter int PTR_W  = 1
) (
    input  logic [NUM_CH-1:0] pending,
    input  logic [PTR_W-1:0]  last_grant,
    input  logic              mode,
    output logic [NUM_CH-1:0] winner,
    output logic [PTR_W-1:0]  winner_idx
);

    always_comb begin
        int  c;
        logic found;
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        c          = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (mode)
                c = (int'(last_grant) + 1 + k) % NUM_CH;
            else
                c = k;
            if (!found && pending[c]) begin
                found      = 1'b1;
                winner[c]  = 1'b1;
                winner_idx = PTR_W'(c);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// N-channel arbiter merging cache request ports onto one memory port, with a
// per-request timeout that returns an error pulse to the owning channel.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ARB_MODE   = 1,
    parameter int TIMEOUT    = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]     ch_addr,
    input  logic [NUM_CH-1:0]                ch_rreq,
    input  logic [NUM_CH-1:0]                ch_wreq,
    input  logic [NUM_CH*DATA_WIDTH-1:0]     ch_wdata,
    input  logic [NUM_CH*(DATA_WIDTH/8)-1:0] ch_byte_enable,
    output logic [DATA_WIDTH-1:0]            ch_rdata,
    output logic [NUM_CH-1:0]                ch_rvalid,
    output logic [NUM_CH-1:0]                ch_wvalid,
    output logic [NUM_CH-1:0]                ch_error,
    output logic [NUM_CH-1:0]                grant,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic                             mem_rreq,
    output logic                             mem_wreq,
    output logic [DATA_WIDTH-1:0]            mem_wdata,
    output logic [DATA_WIDTH/8-1:0]          mem_byte_enable,
    input  logic [DATA_WIDTH-1:0]            mem_rdata,
    input  logic                             mem_rvalid,
    input  logic                             mem_wvalid
);

    localparam int   BE_W  = DATA_WIDTH / 8;
    localparam int   PTR_W = clog2_min1(NUM_CH);
    localparam int   CNT_W = clog2_min1(TIMEOUT + 1);
    localparam logic MODE  = (ARB_MODE == ARB_RR);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT != 0) ? CNT_W'(TIMEOUT - 1) : '0;

    arb_state_e                state_q, state_d;
    logic [PTR_W-1:0]          last_grant_q, last_grant_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [NUM_CH-1:0]         pending, win_onehot;
    logic [PTR_W-1:0]          win_idx;

    logic [NUM_CH-1:0]         grant_d, rvalid_d, wvalid_d, error_d;
    logic [DATA_WIDTH-1:0]     rdata_d, wdata_d;
    logic [ADDR_WIDTH-1:0]     addr_d;
    logic [BE_W-1:0]           be_d;
    logic                      rreq_d, wreq_d;

    assign pending = ch_rreq | ch_wreq;

    arb_picker #(
        .NUM_CH (NUM_CH),
        .PTR_W  (PTR_W)
    ) u_picker (
        .pending    (pending),
        .last_grant (last_grant_q),
        .mode       (MODE),
        .winner     (win_onehot),
        .winner_idx (win_idx)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        grant_d      = grant;
        addr_d       = mem_addr;
        wdata_d      = mem_wdata;
        be_d         = mem_byte_enable;
        rreq_d       = mem_rreq;
        wreq_d       = mem_wreq;
        rdata_d      = ch_rdata;
        rvalid_d     = '0;
        wvalid_d     = '0;
        error_d      = '0;

        case (state_q)
            ARB_IDLE: begin
                if (|pending) begin
                    grant_d      = win_onehot;
                    last_grant_d = win_idx;
                    addr_d       = ch_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d      = ch_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
                    be_d         = ch_byte_enable[win_idx*BE_W +: BE_W];
                    // Write takes precedence; a simultaneous read waits for a later grant.
                    wreq_d       = ch_wreq[win_idx];
                    rreq_d       = !ch_wreq[win_idx] && ch_rreq[win_idx];
                    cnt_d        = '0;
                    state_d      = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (mem_rreq && mem_rvalid) begin
                    rdata_d  = mem_rdata;
                    rvalid_d = grant;
                    rreq_d   = 1'b0;
                    state_d  = ARB_DONE;
                end else if (mem_wreq && mem_wvalid) begin
                    wvalid_d = grant;
                    wreq_d   = 1'b0;
                    state_d  = ARB_DONE;
                end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    error_d  = grant;
                    rreq_d   = 1'b0;
                    wreq_d   = 1'b0;
                    state_d  = ARB_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ARB_DONE: begin
                // Dead cycle so the requester can drop its level request.
                grant_d = '0;
                state_d = ARB_IDLE;
            end
            default: begin
                grant_d = '0;
                rreq_d  = 1'b0;
                wreq_d  = 1'b0;
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= ARB_IDLE;
            last_grant_q    <= PTR_W'(NUM_CH - 1);
            cnt_q           <= '0;
            grant           <= '0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            mem_byte_enable <= '0;
            mem_rreq        <= 1'b0;
            mem_wreq        <= 1'b0;
            ch_rdata        <= '0;
            ch_rvalid       <= '0;
            ch_wvalid       <= '0;
            ch_error        <= '0;
        end else begin
            state_q         <= state_d;
            last_grant_q    <= last_grant_d;
            cnt_q           <= cnt_d;
            grant           <= grant_d;
            mem_addr        <= addr_d;
            mem_wdata       <= wdata_d;
            mem_byte_enable <= be_d;
            mem_rreq        <= rreq_d;
            mem_wreq        <= wreq_d;
            ch_rdata        <= rdata_d;
            ch_rvalid       <= rvalid_d;
            ch_wvalid       <= wvalid_d;
            ch_error        <= error_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a 2-channel round-robin instance with an
// 8-cycle timeout, plus 4-channel round-robin and fixed instances.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int ncomp = 0;
    int nfail = 0;

    // 2-channel instance
    logic [63:0] a_addr, a_wdata;
    logic [1:0]  a_rreq, a_wreq;
    logic [7:0]  a_be;
    logic [31:0] a_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic [1:0]  a_rvalid, a_wvalid, a_error, a_grant;
    logic        a_mem_rreq, a_mem_wreq, a_mem_rvalid, a_mem_wvalid;
    logic [3:0]  a_mem_be;

    // 4-channel instances, shared request inputs, self-answering memory
    logic [127:0] q_addr  = '0;
    logic [127:0] q_wdata = '0;
    logic [15:0]  q_be    = '0;
    logic [3:0]   q_rreq  = '0;
    logic [3:0]   q_wreq  = '0;
    logic [31:0]  q_mem_rdata = 32'h0;

    logic [31:0] r_rdata, r_mem_addr, r_mem_wdata;
    logic [3:0]  r_rvalid, r_wvalid, r_error, r_grant, r_mem_be;
    logic        r_mem_rreq, r_mem_wreq, r_mem_rvalid;
    logic [31:0] f_rdata, f_mem_addr, f_mem_wdata;
    logic [3:0]  f_rvalid, f_wvalid, f_error, f_grant, f_mem_be;
    logic        f_mem_rreq, f_mem_wreq, f_mem_rvalid;

    assign r_mem_rvalid = r_mem_rreq;
    assign f_mem_rvalid = f_mem_rreq;

    mem_arbiter #(.NUM_CH(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(1), .TIMEOUT(8)) u_a (
        .clk(clk), .rst(rst),
        .ch_addr(a_addr), .ch_rreq(a_rreq), .ch_wreq(a_wreq), .ch_wdata(a_wdata),
        .ch_byte_enable(a_be), .ch_rdata(a_rdata), .ch_rvalid(a_rvalid),
        .ch_wvalid(a_wvalid), .ch_error(a_error), .grant(a_grant),
        .mem_addr(a_mem_addr), .mem_rreq(a_mem_rreq), .mem_wreq(a_mem_wreq),
        .mem_wdata(a_mem_wdata), .mem_byte_enable(a_mem_be), .mem_rdata(a_mem_rdata),
        .mem_rvalid(a_mem_rvalid), .mem_wvalid(a_mem_wvalid)
    );

    mem_arbiter #(.NUM_CH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(1), .TIMEOUT(64)) u_rr (
        .clk(clk), .rst(rst),
        .ch_addr(q_addr), .ch_rreq(q_rreq), .ch_wreq(q_wreq), .ch_wdata(q_wdata),
        .ch_byte_enable(q_be), .ch_rdata(r_rdata), .ch_rvalid(r_rvalid),
        .ch_wvalid(r_wvalid), .ch_error(r_error), .grant(r_grant),
        .mem_addr(r_mem_addr), .mem_rreq(r_mem_rreq), .mem_wreq(r_mem_wreq),
        .mem_wdata(r_mem_wdata), .mem_byte_enable(r_mem_be), .mem_rdata(q_mem_rdata),
        .mem_rvalid(r_mem_rvalid), .mem_wvalid(1'b0)
    );

    mem_arbiter #(.NUM_CH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(0), .TIMEOUT(64)) u_fx (
        .clk(clk), .rst(rst),
        .ch_addr(q_addr), .ch_rreq(q_rreq), .ch_wreq(q_wreq), .ch_wdata(q_wdata),
        .ch_byte_enable(q_be), .ch_rdata(f_rdata), .ch_rvalid(f_rvalid),
        .ch_wvalid(f_wvalid), .ch_error(f_error), .grant(f_grant),
        .mem_addr(f_mem_addr), .mem_rreq(f_mem_rreq), .mem_wreq(f_mem_wreq),
        .mem_wdata(f_mem_wdata), .mem_byte_enable(f_mem_be), .mem_rdata(q_mem_rdata),
        .mem_rvalid(f_mem_rvalid), .mem_wvalid(1'b0)
    );

    logic [31:0] exp_q[$];
    logic [31:0] rr_q[$];
    logic [31:0] fx_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] prev_r, prev_f;
        a_addr = '0; a_wdata = '0; a_be = '0; a_wreq = '0;
        a_mem_rdata = '0; a_mem_rvalid = 1'b0; a_mem_wvalid = 1'b0;
        a_rreq = 2'b11;
        a_addr[31:0] = 32'h0000_0100;

        // Reset held with requests pending
        repeat (3) cyc();
        chk("rst_grant", 32'(a_grant), 32'h0);
        chk("rst_mem_rreq", 32'(a_mem_rreq), 32'h0);
        chk("rst_mem_addr", a_mem_addr, 32'h0);
        chk("rst_pulses", 32'({a_rvalid, a_wvalid, a_error}), 32'h0);
        chk("rst_rdata", a_rdata, 32'h0);
        rst = 1'b1;
        cyc();
        chk("first_grant", 32'(a_grant), 32'h1);
        chk("rd_mem_rreq", 32'(a_mem_rreq), 32'h1);
        chk("rd_mem_addr", a_mem_addr, 32'h100);

        // Read served two cycles after grant
        cyc();
        a_mem_rdata = 32'hDEAD_BEEF; a_mem_rvalid = 1'b1;
        exp_q.push_back(32'hDEAD_BEEF);
        cyc();
        a_mem_rvalid = 1'b0; a_rreq = 2'b00;
        chk("rd_rvalid", 32'(a_rvalid), 32'h1);
        chk("rd_rdata", a_rdata, exp_q.pop_front());
        chk("rd_mem_rreq_drop", 32'(a_mem_rreq), 32'h0);
        chk("done_grant_held", 32'(a_grant), 32'h1);
        cyc();
        chk("idle_grant", 32'(a_grant), 32'h0);
        chk("rvalid_once", 32'(a_rvalid), 32'h0);
        chk("rdata_hold", a_rdata, 32'hDEAD_BEEF);

        // Write and read together on ch1: write goes first
        a_addr[63:32] = 32'h0000_0200; a_wdata[63:32] = 32'h1234_5678;
        a_be[7:4] = 4'b0011; a_wreq = 2'b10; a_rreq = 2'b10;
        cyc();
        chk("wr_grant", 32'(a_grant), 32'h2);
        chk("wr_mem_wreq", 32'(a_mem_wreq), 32'h1);
        chk("wr_mem_rreq", 32'(a_mem_rreq), 32'h0);
        chk("wr_mem_wdata", a_mem_wdata, 32'h1234_5678);
        chk("wr_mem_be", 32'(a_mem_be), 32'h3);
        chk("wr_mem_addr", a_mem_addr, 32'h200);
        a_mem_rvalid = 1'b1;
        cyc();
        chk("wrong_type_ignored", 32'(a_rvalid), 32'h0);
        chk("wr_still_busy", 32'(a_mem_wreq), 32'h1);
        a_mem_rvalid = 1'b0; a_mem_wvalid = 1'b1;
        cyc();
        a_mem_wvalid = 1'b0; a_wreq = 2'b00;
        chk("wr_wvalid", 32'(a_wvalid), 32'h2);
        chk("wr_mem_wreq_drop", 32'(a_mem_wreq), 32'h0);
        cyc();
        chk("wr_idle", 32'(a_grant), 32'h0);
        cyc();
        chk("rd_after_wr_grant", 32'(a_grant), 32'h2);
        chk("rd_after_wr_rreq", 32'(a_mem_rreq), 32'h1);
        chk("rd_after_wr_wreq", 32'(a_mem_wreq), 32'h0);

        // Memory never answers: error exactly 8 cycles after grant
        for (int i = 1; i < 8; i++) begin
            cyc();
            chk("to_no_error_early", 32'(a_error), 32'h0);
        end
        cyc();
        chk("to_error", 32'(a_error), 32'h2);
        chk("to_no_rvalid", 32'(a_rvalid), 32'h0);
        chk("to_mem_rreq_drop", 32'(a_mem_rreq), 32'h0);
        a_rreq = 2'b00;
        cyc();
        chk("to_idle", 32'(a_grant), 32'h0);
        a_mem_rdata = 32'h0000_0BAD; a_mem_rvalid = 1'b1;
        cyc();
        chk("late_rvalid_dropped", 32'({a_rvalid, a_error}), 32'h0);
        chk("late_rdata_kept", a_rdata, 32'hDEAD_BEEF);
        chk("late_no_grant", 32'(a_grant), 32'h0);
        a_mem_rvalid = 1'b0; a_rreq = 2'b01;

        // Valid on the final timeout cycle wins
        cyc();
        chk("vt_grant", 32'(a_grant), 32'h1);
        for (int i = 1; i < 8; i++) begin
            cyc();
            chk("vt_no_error_early", 32'(a_error), 32'h0);
        end
        a_mem_rdata = 32'hCAFE_F00D; a_mem_rvalid = 1'b1;
        exp_q.push_back(32'hCAFE_F00D);
        cyc();
        a_mem_rvalid = 1'b0; a_rreq = 2'b00;
        chk("vt_rvalid", 32'(a_rvalid), 32'h1);
        chk("vt_no_error", 32'(a_error), 32'h0);
        chk("vt_rdata", a_rdata, exp_q.pop_front());

        // Four channels requesting continuously
        q_rreq = 4'hF;
        rr_q.push_back(32'h1); rr_q.push_back(32'h2); rr_q.push_back(32'h4);
        rr_q.push_back(32'h8); rr_q.push_back(32'h1);
        for (int i = 0; i < 5; i++) fx_q.push_back(32'h1);
        prev_r = '0; prev_f = '0;
        for (int i = 0; i < 60 && (rr_q.size() != 0 || fx_q.size() != 0); i++) begin
            cyc();
            if (r_grant != 4'h0 && prev_r == 4'h0 && rr_q.size() != 0)
                chk("rr_grant", 32'(r_grant), rr_q.pop_front());
            if (f_grant != 4'h0 && prev_f == 4'h0 && fx_q.size() != 0)
                chk("fx_grant", 32'(f_grant), fx_q.pop_front());
            prev_r = r_grant;
            prev_f = f_grant;
        end
        chk("rr_all_seen", 32'(rr_q.size()), 32'h0);
        chk("fx_all_seen", 32'(fx_q.size()), 32'h0);
        q_rreq = 4'h0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
